rpn_sequencer: RTL
==================

// Module: rpn_sequencer
// PURPOSE
//  Program sequencer for the 16-bit stack arithmetic unit. On start, fetches
//  instruction words from a synchronous instruction ROM and issues push/op
//  commands (push, en, op, d) to the unit, one command per instruction.
//  Stops on HALT and presents the final top of stack. Sits between the host
//  (start/done) and the arithmetic unit, and is the unit's only driver.
// PARAMETERS
//  PC_W     10  instruction address width; the program space is 2**PC_W words
//  DEPTH_MAX 1023  stack count at which a PUSH is an overflow
// PORTS
//  clk        in   1       clock; every flop is clocked on its rising edge
//  nrst       in   1       asynchronous active-low reset
//  start      in   1       one-cycle pulse; run from start_addr
//  start_addr in   PC_W    first instruction address
//  imem_rd    out  1       ROM read strobe
//  imem_addr  out  PC_W    ROM address
//  imem_data  in   18      ROM data, valid the cycle after imem_rd
//  au_push    out  1       to unit push
//  au_en      out  1       to unit en
//  au_op      out  3       to unit op
//  au_d       out  16      to unit d (push immediate)
//  au_cnt     in   10      unit stack count
//  au_out     in   16      unit top of stack
//  busy       out  1       high while not IDLE
//  done       out  1       one-cycle pulse when a run ends (HALT or error)
//  error      out  1       sticky; cleared by the next accepted start
//  result     out  16      au_out captured at HALT
//  pc         out  PC_W    address of the current instruction
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE.
//  Instruction word [17:16] kind: 00 PUSH, imm=[15:0] | 01 OP, op=[2:0]
//  | 10 HALT | 11 reserved (illegal).
//  FSM: IDLE -> FETCH -> DECODE -> EXEC -> FETCH ...; SETTLE after op 5.
//   IDLE:   start -> pc=start_addr, error=0, FETCH. start is ignored when busy.
//   FETCH:  imem_rd=1, imem_addr=pc.
//   DECODE: sample imem_data. HALT -> result=au_out, done=1, IDLE.
//           Illegal instruction or depth fault -> error=1, done=1, IDLE,
//           nothing issued to the unit.
//   EXEC:   au_en=1 for exactly one cycle (au_push=1 and au_d=imm for PUSH).
//           pc=pc+1, wrapping from 2**PC_W-1 to 0. Next state is FETCH,
//           or SETTLE for op 5.
//   SETTLE: one cycle with au_en=0 so the unit latches its loaded top.
//  au_* are registered. au_en is low in every state except EXEC.
//  Throughput: 3 cycles per instruction, 4 cycles for op 5.
//  The HALT result reflects all prior commands; done comes 2 cycles after
//  the HALT fetch.
//  Reset mid-run: immediate IDLE; no further au_en.
// CONFIGURATION
//  RPN_SEQ_DEPTH_CHK_EN defined: DECODE checks au_cnt before issuing.
//   - ops 0, 1, 5, 6, 7 need au_cnt >= 1.
//   - ops 2, 3, 4 need au_cnt >= 2.
//   - PUSH needs au_cnt < DEPTH_MAX.
//   A violation is a depth fault.
//  Not defined: no depth check; every legal instruction is issued as is.
//  Reserved kind 11 is always an error.
// STRUCTURE
//  Package rpn_seq_pkg:
//   - instr_kind_e enum (PUSH, OP, HALT, RSVD) and state_e enum.
//   - Field position constants (KIND_HI/LO, IMM_W = 16).
//   - function min_depth(op) returning 1 or 2.
//  Sub-module rpn_seq_decode: combinational; instruction + au_cnt ->
//   kind, op, imm, illegal, depth_fault.
// TESTING
//  1. PUSH 3, PUSH 4, OP 2, HALT -> result=7, done pulse, error=0, 12 cycles
//     from start to done.
//  2. PUSH 5, OP 1, OP 0, HALT -> result=0. Then PUSH 2, PUSH 3, OP 3, HALT
//     -> result=6.
//  3. With the macro: OP 2 on an empty stack -> error=1, done, au_en never
//     high. Without the macro: au_en is pulsed with op=2.
//  4. Word 18'h3_0000 at start_addr -> error=1, done one cycle after DECODE.
//     The next start clears error.
//  5. start_addr=2**PC_W-1 holding PUSH 9, HALT at address 0 -> pc wraps to
//     0, result=9.
//  6. Deassert nrst during EXEC of a long program -> all outputs 0 at once,
//     busy=0. A start pulse while busy -> ignored, pc unchanged.

Source files
------------

// File: rtl/rpn_seq_pkg.sv
// rpn_seq_pkg: shared types, field positions and depth rules for the RPN sequencer
package rpn_seq_pkg;
  localparam int PC_W_DEF = 10;
  localparam int DEPTH_MAX_DEF = 1023;
  localparam int INSTR_W = 18;
  localparam int KIND_HI = 17;
  localparam int KIND_LO = 16;
  localparam int IMM_W = 16;
  localparam int CNT_W = 10;
  typedef enum logic [1:0] {K_PUSH = 2'd0, K_OP = 2'd1, K_HALT = 2'd2, K_RSVD = 2'd3} instr_kind_e;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_SETTLE} state_e;
  function automatic logic [1:0] min_depth(input logic [2:0] op);
    return (op == 3'd2 || op == 3'd3 || op == 3'd4) ? 2'd2 : 2'd1;
  endfunction
endpackage

// File: rtl/rpn_seq_decode.sv
// rpn_seq_decode: splits an instruction word and flags illegal kinds and stack depth faults (RPN_SEQ_DEPTH_CHK_EN)
module rpn_seq_decode
  import rpn_seq_pkg::*;
#(
  parameter int DEPTH_MAX = DEPTH_MAX_DEF
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic [CNT_W-1:0]   au_cnt,
  output instr_kind_e        kind,
  output logic [2:0]         op,
  output logic [IMM_W-1:0]   imm,
  output logic               illegal,
  output logic               depth_fault
);
  assign kind = instr_kind_e'(instr[KIND_HI:KIND_LO]);
  assign op = instr[2:0];
  assign imm = instr[IMM_W-1:0];
  assign illegal = kind == K_RSVD;
`ifdef RPN_SEQ_DEPTH_CHK_EN
  assign depth_fault = (kind == K_PUSH) ? (32'(au_cnt) >= DEPTH_MAX) :
                       (kind == K_OP) ? (au_cnt < CNT_W'(min_depth(op))) : 1'b0;
`else
  logic unused_cnt;
  assign unused_cnt = ^au_cnt;
  assign depth_fault = 1'b0;
`endif
endmodule

// File: rtl/rpn_sequencer.sv
// rpn_sequencer: fetches ROM instructions and issues push/op commands to the stack unit (optional depth check: RPN_SEQ_DEPTH_CHK_EN)
module rpn_sequencer
  import rpn_seq_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int DEPTH_MAX = DEPTH_MAX_DEF
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               start,
  input  logic [PC_W-1:0]    start_addr,
  output logic               imem_rd,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               au_push,
  output logic               au_en,
  output logic [2:0]         au_op,
  output logic [IMM_W-1:0]   au_d,
  input  logic [CNT_W-1:0]   au_cnt,
  input  logic [IMM_W-1:0]   au_out,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [IMM_W-1:0]   result,
  output logic [PC_W-1:0]    pc
);
  state_e state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic imem_rd_q, imem_rd_d, au_en_q, au_en_d, au_push_q, au_push_d;
  logic done_q, done_d, error_q, error_d;
  logic [2:0] au_op_q, au_op_d;
  logic [IMM_W-1:0] au_d_q, au_d_d, result_q, result_d;
  instr_kind_e kind;
  logic [2:0] op;
  logic [IMM_W-1:0] imm;
  logic illegal, depth_fault;
  rpn_seq_decode #(.DEPTH_MAX(DEPTH_MAX)) u_dec (
    .instr(imem_data), .au_cnt(au_cnt), .kind(kind), .op(op), .imm(imm),
    .illegal(illegal), .depth_fault(depth_fault)
  );
  // Next-state and next-output logic; every output is registered so it is valid for the whole state
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    imem_rd_d = 1'b0;
    au_en_d = 1'b0;
    au_push_d = 1'b0;
    au_op_d = au_op_q;
    au_d_d = au_d_q;
    done_d = 1'b0;
    error_d = error_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_FETCH;
        pc_d = start_addr;
        error_d = 1'b0;
        imem_rd_d = 1'b1;
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: if (kind == K_HALT) begin
        state_d = S_IDLE;
        result_d = au_out;
        done_d = 1'b1;
      end else if (illegal || depth_fault) begin
        state_d = S_IDLE;
        error_d = 1'b1;
        done_d = 1'b1;
      end else begin
        state_d = S_EXEC;
        au_en_d = 1'b1;
        au_push_d = kind == K_PUSH;
        au_op_d = (kind == K_OP) ? op : 3'd0;
        au_d_d = (kind == K_PUSH) ? imm : au_d_q;
      end
      S_EXEC: begin
        pc_d = pc_q + PC_W'(1);
        state_d = (!au_push_q && au_op_q == 3'd5) ? S_SETTLE : S_FETCH;
        imem_rd_d = state_d == S_FETCH;
      end
      S_SETTLE: begin
        state_d = S_FETCH;
        imem_rd_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // State and output registers; reset drops everything to IDLE immediately
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      pc_q <= '0;
      imem_rd_q <= 1'b0;
      au_en_q <= 1'b0;
      au_push_q <= 1'b0;
      au_op_q <= 3'd0;
      au_d_q <= '0;
      done_q <= 1'b0;
      error_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      imem_rd_q <= imem_rd_d;
      au_en_q <= au_en_d;
      au_push_q <= au_push_d;
      au_op_q <= au_op_d;
      au_d_q <= au_d_d;
      done_q <= done_d;
      error_q <= error_d;
      result_q <= result_d;
    end
  end
  assign imem_rd = imem_rd_q;
  assign imem_addr = pc_q;
  assign au_push = au_push_q;
  assign au_en = au_en_q;
  assign au_op = au_op_q;
  assign au_d = au_d_q;
  assign busy = state_q != S_IDLE;
  assign done = done_q;
  assign error = error_q;
  assign result = result_q;
  assign pc = pc_q;
endmodule
